// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start, cin, busy, done, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master(output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave(input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder processing DIGIT bits per clock through one registered carry
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst_n,
  serial_adder_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, res, res_n;
  logic [DIGIT:0] dsum;
  logic [CW-1:0] cnt;
  logic carry, msb_a, msb_b;
  assign dsum = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign res_n = (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT)) | (res >> DIGIT);
  assign bus.busy = state == RUN;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // accept start only when idle; leave RUN after the last digit
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) : (cnt == '0 ? IDLE : RUN);
  end
  // operand capture, digit processing and result publication
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      res <= '0;
      carry <= 1'b0;
      cnt <= '0;
      msb_a <= 1'b0;
      msb_b <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE && bus.start) begin
        ra <= bus.a;
        rb <= bus.b;
        carry <= bus.cin;
        cnt <= CW'(N - 1);
        msb_a <= bus.a[WIDTH-1];
        msb_b <= bus.b[WIDTH-1];
      end else if (state == RUN) begin
        ra <= ra >> DIGIT;
        rb <= rb >> DIGIT;
        carry <= dsum[DIGIT];
        res <= res_n;
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          bus.sum <= res_n;
          bus.cout <= dsum[DIGIT];
          bus.ovf <= (msb_a == msb_b) && (res_n[WIDTH-1] != msb_a);
          bus.done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder in several WIDTH/DIGIT configurations
module tb_serial_adder;
  logic clk = 0, rst_n = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_adder_if #(8) i81();
  serial_adder_if #(8) i84();
  serial_adder_if #(4) i41();
  serial_adder_if #(4) i42();
  serial_adder_if #(4) i44();
  serial_adder #(.WIDTH(8), .DIGIT(1)) u81(.clk(clk), .rst_n(rst_n), .bus(i81));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u84(.clk(clk), .rst_n(rst_n), .bus(i84));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u41(.clk(clk), .rst_n(rst_n), .bus(i41));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u42(.clk(clk), .rst_n(rst_n), .bus(i42));
  serial_adder #(.WIDTH(4), .DIGIT(4)) u44(.clk(clk), .rst_n(rst_n), .bus(i44));

  // start one W8/D1 operation now (just after a falling edge) and wait for done;
  // lat counts edges from the start edge up to the one that raises done
  task automatic go81(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output int lat, output int busy_n, output bit stable);
    logic [7:0] hold;
    hold = i81.sum;
    stable = 1;
    busy_n = 0;
    i81.start = 1; i81.a = a; i81.b = b; i81.cin = cin;
    @(negedge clk);
    i81.start = 0;
    lat = 1;
    while (!i81.done && lat < 20) begin
      busy_n += int'(i81.busy);
      if (i81.sum !== hold) stable = 0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({i81.busy, i81.done, i81.sum, i81.cout, i81.ovf} !== 11'd0) begin
      n_bad++; $display("FAIL reset_w8d1: got %b want 0", {i81.busy, i81.done, i81.sum, i81.cout, i81.ovf});
    end
    n_cmp++;
    if ({i84.busy, i84.done, i84.sum, i84.cout, i84.ovf} !== 11'd0) begin
      n_bad++; $display("FAIL reset_w8d4: got %b want 0", {i84.busy, i84.done, i84.sum, i84.cout, i84.ovf});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bn;
    bit st;
    go81(8'h3C, 8'h5A, 1'b0, lat, bn, st);
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++;
    if (bn !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bn); end
    n_cmp++;
    if ({i81.sum, i81.cout, i81.ovf} !== {8'h96, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL basic_result: got %h/%b/%b want 96/0/1", i81.sum, i81.cout, i81.ovf);
    end
  endtask

  task automatic test_hold;
    int lat, bn;
    bit st;
    go81(8'hFF, 8'h01, 1'b1, lat, bn, st);
    n_cmp++;
    if ({i81.sum, i81.cout, i81.ovf} !== {8'h01, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL carry_result: got %h/%b/%b want 01/1/0", i81.sum, i81.cout, i81.ovf);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({i81.done, i81.busy, i81.sum, i81.cout, i81.ovf} !== {2'b00, 8'h01, 1'b1, 1'b0}) begin
        n_bad++; $display("FAIL idle_hold_%0d: got %b/%b/%h/%b/%b want 0/0/01/1/0", k,
                          i81.done, i81.busy, i81.sum, i81.cout, i81.ovf);
      end
    end
  endtask

  task automatic test_digit4;
    int lat, bn;
    i84.start = 1; i84.a = 8'h80; i84.b = 8'h80; i84.cin = 0;
    @(negedge clk);
    i84.start = 0;
    lat = 1; bn = 0;
    while (!i84.done && lat < 20) begin
      bn += int'(i84.busy);
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL d4_latency: got %0d want 3", lat); end
    n_cmp++;
    if (bn !== 2) begin n_bad++; $display("FAIL d4_busy_cycles: got %0d want 2", bn); end
    n_cmp++;
    if ({i84.sum, i84.cout, i84.ovf} !== {8'h00, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL d4_result: got %h/%b/%b want 00/1/1", i84.sum, i84.cout, i84.ovf);
    end
    @(negedge clk);
    n_cmp++;
    if (i84.done !== 1'b0) begin n_bad++; $display("FAIL d4_done_pulse: got %b want 0", i84.done); end
  endtask

  task automatic test_ignore_start;
    i81.start = 1; i81.a = 8'h11; i81.b = 8'h22; i81.cin = 0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      i81.start = (k == 2 || k == 4);
      i81.a = 8'($urandom); i81.b = 8'($urandom); i81.cin = k[0];
      @(negedge clk);
    end
    i81.start = 0;
    n_cmp++;
    if (i81.done !== 1'b1) begin n_bad++; $display("FAIL ignore_done: got %b want 1", i81.done); end
    n_cmp++;
    if ({i81.sum, i81.cout, i81.ovf} !== {8'h33, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL ignore_result: got %h/%b/%b want 33/0/0", i81.sum, i81.cout, i81.ovf);
    end
    @(negedge clk);
    n_cmp++;
    if ({i81.busy, i81.done} !== 2'b00) begin
      n_bad++; $display("FAIL ignore_no_queue: got busy/done %b want 00", {i81.busy, i81.done});
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    bit st;
    go81(8'h01, 8'h02, 1'b0, lat, bn, st);
    n_cmp++;
    if (i81.sum !== 8'h03) begin n_bad++; $display("FAIL b2b_first: got %h want 03", i81.sum); end
    go81(8'h10, 8'h20, 1'b0, lat, bn, st);
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL b2b_latency: got %0d want 9", lat); end
    n_cmp++;
    if (st !== 1'b1) begin n_bad++; $display("FAIL b2b_first_held: got %b want 1", st); end
    n_cmp++;
    if ({i81.sum, i81.cout, i81.ovf} !== {8'h30, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL b2b_second: got %h/%b/%b want 30/0/0", i81.sum, i81.cout, i81.ovf);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bn;
    bit st, seen;
    i81.start = 1; i81.a = 8'h3C; i81.b = 8'h5A; i81.cin = 0;
    @(negedge clk);
    i81.start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({i81.busy, i81.done, i81.sum, i81.cout, i81.ovf} !== 11'd0) begin
      n_bad++; $display("FAIL async_reset: got %b want 0", {i81.busy, i81.done, i81.sum, i81.cout, i81.ovf});
    end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (i81.done || i81.busy) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL aborted_done: got activity %b want 0", seen); end
    go81(8'h05, 8'h07, 1'b0, lat, bn, st);
    n_cmp++;
    if (lat !== 9 || i81.sum !== 8'h0C) begin
      n_bad++; $display("FAIL after_reset: got lat %0d sum %h want 9 0c", lat, i81.sum);
    end
  endtask

  task automatic test_sweep;
    logic [4:0] r1, r2, r4, exp_r;
    logic o1, o2, o4, exp_o;
    int l1, l2, l4, s;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          {i41.a, i42.a, i44.a} = {3{4'(a)}};
          {i41.b, i42.b, i44.b} = {3{4'(b)}};
          {i41.cin, i42.cin, i44.cin} = {3{1'(c)}};
          {i41.start, i42.start, i44.start} = 3'b111;
          @(negedge clk);
          {i41.start, i42.start, i44.start} = 3'b000;
          l1 = 0; l2 = 0; l4 = 0;
          r1 = 'x; r2 = 'x; r4 = 'x; o1 = 'x; o2 = 'x; o4 = 'x;
          for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            if (i41.done && l1 == 0) begin l1 = k; r1 = {i41.cout, i41.sum}; o1 = i41.ovf; end
            if (i42.done && l2 == 0) begin l2 = k; r2 = {i42.cout, i42.sum}; o2 = i42.ovf; end
            if (i44.done && l4 == 0) begin l4 = k; r4 = {i44.cout, i44.sum}; o4 = i44.ovf; end
          end
          exp_r = 5'(a + b + c);
          s = (a > 7 ? a - 16 : a) + (b > 7 ? b - 16 : b) + c;
          exp_o = s > 7 || s < -8;
          n_cmp++;
          if (l1 !== 5 || r1 !== exp_r || o1 !== exp_o) begin
            n_bad++; $display("FAIL sweep_d1 a=%0d b=%0d c=%0d: got lat %0d %h ovf %b want 5 %h %b", a, b, c, l1, r1, o1, exp_r, exp_o);
          end
          n_cmp++;
          if (l2 !== 3 || r2 !== exp_r || o2 !== exp_o) begin
            n_bad++; $display("FAIL sweep_d2 a=%0d b=%0d c=%0d: got lat %0d %h ovf %b want 3 %h %b", a, b, c, l2, r2, o2, exp_r, exp_o);
          end
          n_cmp++;
          if (l4 !== 2 || r4 !== exp_r || o4 !== exp_o) begin
            n_bad++; $display("FAIL sweep_d4 a=%0d b=%0d c=%0d: got lat %0d %h ovf %b want 2 %h %b", a, b, c, l4, r4, o4, exp_r, exp_o);
          end
        end
  endtask

  initial begin
    {i81.start, i81.a, i81.b, i81.cin} = '0;
    {i84.start, i84.a, i84.b, i84.cin} = '0;
    {i41.start, i41.a, i41.b, i41.cin} = '0;
    {i42.start, i42.a, i42.b, i42.cin} = '0;
    {i44.start, i44.a, i44.b, i44.cin} = '0;
    test_reset;
    test_basic;
    test_hold;
    test_digit4;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
